// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets the fetch path (I) and the load/store path (D) share one
// single-port memory. It runs one transaction at a time, bounds every memory wait
// with a timeout, and returns data plus a one-cycle done pulse to the requester
// that owns the transaction.
// Build option: define ARB_RR_EN to alternate between I and D when both request
// together. Without it, D always has priority over I.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16      // 1..255
) (
    input  logic          clk,
    input  logic          reset,     // async, active low
    // fetch side
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic          i_err,
    output logic [DW-1:0] i_rdata,
    // load/store side
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    // memory side
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    // The wait counter is 8 bits wide, which covers the full TIMEOUT range.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          mem_req_d, mem_we_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;
    logic          i_done_d, i_err_d, d_done_d, d_err_d, bus_err_d;
    logic [DW-1:0] i_rdata_d, d_rdata_d;

    // A requester whose done is high this cycle is still dropping its old
    // request, so it cannot start a new transaction yet.
    logic          i_elig, d_elig, pick_d;

    assign i_elig = i_req & ~i_done;
    assign d_elig = d_req & ~d_done;

`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;   // 1 = D completed most recently

    // On a tie, grant the requester that did not complete most recently.
    // After reset I counts as the last grant, so D wins the first tie.
    assign pick_d = d_elig & (~i_elig | ~last_d_q);
`else
    assign pick_d = d_elig;
`endif

    // Next-state and next-output logic. The memory-side signals hold by default.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        i_done_d    = 1'b0;
        i_err_d     = i_err;
        i_rdata_d   = i_rdata;
        d_done_d    = 1'b0;
        d_err_d     = d_err;
        d_rdata_d   = d_rdata;
        bus_err_d   = bus_err;
`ifdef ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                    state_d     = BUSY_D;
                end else if (i_elig) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                    state_d     = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    // A ready in the last allowed cycle still completes normally.
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_err_d   = 1'b0;
                        i_rdata_d = mem_rdata;
                    end else begin
                        d_done_d  = 1'b1;
                        d_err_d   = 1'b0;
                        d_rdata_d = mem_we ? '0 : mem_rdata;
                    end
`ifdef ARB_RR_EN
                    last_d_d = (state_q == BUSY_D);
`endif
                end else if (cnt_q == TO_LAST) begin
                    // Abort: report the error to the owner and set the sticky flag.
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    if (state_q == BUSY_I) begin
                        i_done_d  = 1'b1;
                        i_err_d   = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset drops any transaction that is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            i_done    <= i_done_d;
            i_err     <= i_err_d;
            i_rdata   <= i_rdata_d;
            d_done    <= d_done_d;
            d_err     <= d_err_d;
            d_rdata   <= d_rdata_d;
            bus_err   <= bus_err_d;
        end
    end

`ifdef ARB_RR_EN
    // Remembers which requester completed most recently, for the round-robin tie-break.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_d_q <= 1'b0;
        else        last_d_q <= last_d_d;
    end
`endif

endmodule
